fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Producer side of the fetch/decode pipeline register: generates the instruction word, PC and PC+2, plus a bubble flag, that the IF/ID register captures each cycle.
- Owns the PC. Runs a single-outstanding request/done handshake to a multi-cycle instruction memory.
- Buffers returned words in a 2-entry queue so that decode stalls never lose data.
- Handles branch/jump redirects and HALT.

Parameters:
NOP_INST, 16'h0800, word driven on inst_out when no valid instruction is present
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall_in  in  1  decode stall from hazard unit; head entry is not consumed this cycle
redirect_valid  in  1  branch/jump resolved taken; flush and refetch
redirect_pc  in  16  redirect target
halt_in  in  1  HALT decoded; stop fetching
imem_rd  out  1  memory request, held until imem_done
imem_addr  out  16  request address, stable while imem_rd=1
imem_data  in  16  instruction word, valid when imem_done=1
imem_done  in  1  request complete (earliest: same cycle as first imem_rd)
inst_out  out  16  queue head instruction or NOP_INST
pc_out_out  out  16  PC of inst_out
pc_inc_out  out  16  pc_out_out+2, modulo 2^16
stall_out  out  1  1 = bubble (queue empty); drives IF/ID stall_in

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, queue count=0, imem_rd=0, inst_out=NOP_INST, pc_out_out=0, pc_inc_out=2, stall_out=1.
- States: IDLE, REQ, DRAIN, HALTED.
- IDLE -> REQ on the first clock after reset release.
- REQ: imem_rd=1, imem_addr=fetch_pc.
  - Requests are issued only while count<=1, so one slot is always free for the outstanding word.
  - On imem_done: push {imem_data, fetch_pc} at the tail; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000.
  - Stay in REQ if count after the push/pop is <=1; otherwise imem_rd drops (REQ idles) until a pop frees space.
- Queue pop: occurs at the clock edge when count>=1 and stall_in=0. Push and pop in the same cycle leave count unchanged. Entries stay in order.
- Outputs are combinational from the queue head.
  - count=0: inst_out=NOP_INST, stall_out=1, pc_out_out=fetch_pc, pc_inc_out=fetch_pc+2.
- Latency: imem_done at edge N puts the word on inst_out after edge N when the queue was empty.
- redirect_valid=1 has priority over stall_in, halt_in and imem_done:
  - The queue is cleared; the head is not counted as consumed. fetch_pc <= {redirect_pc[15:1],1'b0}; bit0 is ignored.
  - If a request is outstanding and imem_done=0: state -> DRAIN. imem_rd stays 1 at the old address until imem_done; that word is discarded; then -> REQ at the new PC.
  - If imem_done=1 in the same cycle as redirect_valid: the word is discarded and state -> REQ.
  - stall_out=1 from the cycle after the redirect until the first new word arrives.
- DRAIN: no pushes. A second redirect during DRAIN updates fetch_pc only; the state remains DRAIN.
- halt_in=1 with redirect_valid=0:
  - The queue is cleared and the outstanding request is completed and discarded (as in DRAIN).
  - State -> HALTED: imem_rd=0, stall_out=1, inst_out=NOP_INST.
  - HALTED is left only by reset; redirect_valid is ignored there.
- stall_in=1 with count=0 has no effect.
- Reset mid-request drops imem_rd immediately (asynchronous); the memory must tolerate an abandoned request.

Test Plan:
- Reset then imem_done one cycle after each imem_rd (imem_data=16'h1111, 16'h2222, ...), stall_in=0 -> stall_out=1 and inst_out=16'h0800 during reset; imem_addr sequence 0, 2, 4; inst_out 1111/pc_out_out 0/pc_inc_out 2, then 2222/2/4.
- stall_in held high for 5 cycles with 0-wait memory -> queue fills to 2 and imem_rd drops; inst_out stays on head 16'h1111. On release, 16'h1111 then 16'h2222 are presented on consecutive cycles, with no loss or duplication.
- redirect_valid with redirect_pc=16'h0041 while a request is outstanding and the queue holds 2 entries -> queue cleared, stall_out=1; the next imem_done word is discarded; the next imem_addr is 16'h0040.
- redirect_valid and imem_done in the same cycle, together with stall_in=1 -> word dropped, stall ignored; the next request goes to the redirect target.
- PC wrap: redirect to 16'hFFFE -> word presented with pc_out_out=16'hFFFE and pc_inc_out=16'h0000; the next imem_addr is 16'h0000.
- halt_in pulse -> imem_rd stays 0 and stall_out stays 1 permanently; a subsequent redirect_valid has no effect; asserting rst=0 mid-request restores all reset values asynchronously, with no clock edge.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/done handshake between the fetch unit and a
// multi-cycle instruction memory (single outstanding request).
interface fetch_queue_unit_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;

  modport master (output imem_rd, output imem_addr, input imem_data, input imem_done);
  modport slave  (input imem_rd, input imem_addr, output imem_data, output imem_done);
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage producer: owns the PC, runs the imem handshake, buffers words in a
// 2-entry queue and presents the head (or a NOP bubble) to the IF/ID register.
module fetch_queue_unit #(
  parameter logic [15:0] NOP_INST = 16'h0800,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  input  logic                halt_in,
  fetch_queue_unit_if.master  imem,
  output logic [15:0]         inst_out,
  output logic [15:0]         pc_out_out,
  output logic [15:0]         pc_inc_out,
  output logic                stall_out
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALTED} state_t;

  state_t      state, state_nx;
  logic [15:0] fetch_pc, pc_nx;
  logic [15:0] req_addr;
  logic        halt_pend, halt_nx;
  logic [1:0]  count;
  logic [31:0] q0, q1;
  logic        rd, push, pop, flush, capture;
  logic [15:0] redir_al;

  assign redir_al = redirect_pc & 16'hFFFE;

  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    halt_nx  = halt_pend;
    rd       = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        state_nx = REQ;
        if (redirect_valid) begin
          flush = 1'b1;
          pc_nx = redir_al;
        end else if (halt_in) begin
          flush    = 1'b1;
          state_nx = HALTED;
        end
      end
      REQ: begin
        rd = (count <= 2'd1);
        if (redirect_valid || halt_in) begin
          flush = 1'b1;
          if (redirect_valid) pc_nx = redir_al;
          // An in-flight request must still complete; park in DRAIN and remember
          // whether HALTED or REQ follows.
          if (rd && !imem.imem_done) begin
            state_nx = DRAIN;
            capture  = 1'b1;
            halt_nx  = !redirect_valid;
          end else if (!redirect_valid) begin
            state_nx = HALTED;
          end
        end else begin
          pop  = (count != 2'd0) && !stall_in;
          push = rd && imem.imem_done;
          if (push) pc_nx = fetch_pc + 16'd2;
        end
      end
      DRAIN: begin
        rd = 1'b1;
        if (redirect_valid) pc_nx = redir_al;
        if (halt_in && !redirect_valid) halt_nx = 1'b1;
        if (imem.imem_done)
          state_nx = (halt_pend || (halt_in && !redirect_valid)) ? HALTED : REQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      halt_pend <= 1'b0;
      count     <= '0;
      q0        <= '0;
      q1        <= '0;
    end else begin
      fetch_pc  <= pc_nx;
      halt_pend <= halt_nx;
      if (capture) req_addr <= fetch_pc;
      if (flush) begin
        count <= '0;
      end else if (push && pop) begin
        // Push is only possible at count<=1, so a simultaneous pop leaves the new word at the head.
        q0 <= {imem.imem_data, fetch_pc};
      end else if (pop) begin
        q0    <= q1;
        count <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) q0 <= {imem.imem_data, fetch_pc};
        else               q1 <= {imem.imem_data, fetch_pc};
        count <= count + 2'd1;
      end
    end
  end

  assign imem.imem_rd   = rd;
  assign imem.imem_addr = (state == DRAIN) ? req_addr : fetch_pc;

  always_comb begin
    if (count == 2'd0) begin
      inst_out   = NOP_INST;
      pc_out_out = fetch_pc;
      stall_out  = 1'b1;
    end else begin
      inst_out   = q0[31:16];
      pc_out_out = q0[15:0];
      stall_out  = 1'b0;
    end
    pc_inc_out = pc_out_out + 16'd2;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: cycle table plus hand-written reset and
// full-queue redirect sequences.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, redirect_valid, halt_in;
  logic [15:0] redirect_pc;
  logic [15:0] inst_out, pc_out_out, pc_inc_out;
  logic        stall_out;

  fetch_queue_unit_if imem_bus ();

  fetch_queue_unit #(.NOP_INST(16'h0800), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .imem           (imem_bus),
    .inst_out       (inst_out),
    .pc_out_out     (pc_out_out),
    .pc_inc_out     (pc_inc_out),
    .stall_out      (stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, rv;
    logic [15:0] rpc;
    logic        ht, dn;
    logic [15:0] dat;
    logic        e_rd;
    logic [15:0] e_addr, e_inst, e_pc;
    logic        e_stall;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic st, rv, input logic [15:0] rpc, input logic ht, dn,
                     input logic [15:0] dat, input logic e_rd, input logic [15:0] e_addr,
                     e_inst, e_pc, input logic e_stall);
    vec_t v;
    v = '{st, rv, rpc, ht, dn, dat, e_rd, e_addr, e_inst, e_pc, e_stall};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, rv, input logic [15:0] rpc, input logic ht, dn,
                       input logic [15:0] dat);
    stall_in               = st;
    redirect_valid         = rv;
    redirect_pc            = rpc;
    halt_in                = ht;
    imem_bus.imem_done     = dn;
    imem_bus.imem_data     = dat;
  endtask

  task automatic chk_out(input string tag, input logic e_rd, input logic [15:0] e_addr,
                         e_inst, e_pc, input logic e_stall);
    chk({tag, " imem_rd"}, {15'd0, imem_bus.imem_rd}, {15'd0, e_rd});
    if (e_rd) chk({tag, " imem_addr"}, imem_bus.imem_addr, e_addr);
    chk({tag, " inst_out"}, inst_out, e_inst);
    chk({tag, " pc_out_out"}, pc_out_out, e_pc);
    chk({tag, " pc_inc_out"}, pc_inc_out, e_pc + 16'd2);
    chk({tag, " stall_out"}, {15'd0, stall_out}, {15'd0, e_stall});
  endtask

  initial begin
    //   st rv rpc      ht dn dat       | rd addr      inst      pc        stall
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 1, 16'h1111,  1, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0002, 16'h1111, 16'h0000, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h2222,  1, 16'h0002, 16'h0800, 16'h0002, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0004, 16'h2222, 16'h0002, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h3333,  1, 16'h0004, 16'h0800, 16'h0004, 1);
    add(1, 0, 16'h0000, 0, 1, 16'h4444,  1, 16'h0006, 16'h3333, 16'h0004, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0008, 16'h3333, 16'h0004, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0008, 16'h3333, 16'h0004, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0008, 16'h3333, 16'h0004, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0008, 16'h3333, 16'h0004, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h5555,  1, 16'h0008, 16'h4444, 16'h0006, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h000A, 16'h5555, 16'h0008, 0);
    add(1, 1, 16'h0041, 0, 0, 16'h0000,  1, 16'h000A, 16'h5555, 16'h0008, 0);
    add(0, 0, 16'h0000, 0, 1, 16'hDEAD,  1, 16'h000A, 16'h0800, 16'h0040, 1);
    add(0, 0, 16'h0000, 0, 1, 16'h6666,  1, 16'h0040, 16'h0800, 16'h0040, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0042, 16'h6666, 16'h0040, 0);
    add(1, 1, 16'hFFFE, 0, 1, 16'hBAD1,  1, 16'h0042, 16'h6666, 16'h0040, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h7777,  1, 16'hFFFE, 16'h0800, 16'hFFFE, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 16'h7777, 16'hFFFE, 0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 1, 16'hBAD2,  1, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 1, 16'h1234, 0, 0, 16'h0000,  0, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 1, 16'h9999,  0, 16'h0000, 16'h0800, 16'h0000, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 16'h0800, 16'h0000, 1);

    rst = 1'b0;
    drive(0, 0, 16'h0000, 0, 0, 16'h0000);
    #2;
    chk_out("reset", 0, 16'h0000, 16'h0800, 16'h0000, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].rv, vq[i].rpc, vq[i].ht, vq[i].dn, vq[i].dat);
      #1;
      chk_out($sformatf("v%0d", i), vq[i].e_rd, vq[i].e_addr, vq[i].e_inst, vq[i].e_pc,
              vq[i].e_stall);
      @(negedge clk);
    end

    // Reset out of HALTED, then asynchronous reset while a request is up.
    drive(0, 0, 16'h0000, 0, 0, 16'h0000);
    rst = 1'b0;
    #1;
    chk_out("rst_halted", 0, 16'h0000, 16'h0800, 16'h0000, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_out("rereq", 1, 16'h0000, 16'h0800, 16'h0000, 1);
    #1;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 16'h0000, 16'h0800, 16'h0000, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill the queue with 0-wait memory, then redirect with nothing outstanding.
    drive(1, 0, 16'h0000, 0, 1, 16'hA001);
    #1;
    chk_out("full0", 1, 16'h0000, 16'h0800, 16'h0000, 1);
    @(negedge clk);
    drive(1, 0, 16'h0000, 0, 1, 16'hA002);
    #1;
    chk_out("full1", 1, 16'h0002, 16'hA001, 16'h0000, 0);
    @(negedge clk);
    drive(1, 1, 16'h0101, 0, 0, 16'h0000);
    #1;
    chk_out("full2", 0, 16'h0004, 16'hA001, 16'h0000, 0);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 1, 16'hB001);
    #1;
    chk_out("redir_full", 1, 16'h0100, 16'h0800, 16'h0100, 1);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 0, 16'h0000);
    #1;
    chk_out("redir_word", 1, 16'h0102, 16'hB001, 16'h0100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
